// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers one stereo pair and shifts it out left-justified, MSB-first, to a slave-mode codec DAC
module audio_dac_serializer #(
    parameter int DATA_W   = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic              iCLK,
    input  logic              reset_h,
    input  logic [DATA_W-1:0] iL,
    input  logic [DATA_W-1:0] iR,
    input  logic              iValid,
    output logic              oReady,
    output logic              oAUD_BCK,
    output logic              oAUD_LRCK,
    output logic              oAUD_DATA,
    output logic              oFrame,
    output logic              oUnderrun
);
    localparam int FW = 2 * DATA_W;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int IW = $clog2(FW);

    logic [DW-1:0]     div;
    logic [IW-1:0]     bit_idx;
    logic [IW-1:0]     next_idx;
    logic [FW-1:0]     shift;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full;
    logic              terminal;
    logic              fall;
    logic              wrap;
    logic              accept;

    assign oReady = ~hold_full;

    // edge detection: a bit slot advances only when BCLK is about to go 1->0
    always_comb begin
        terminal = div == DW'(BCLK_DIV - 1);
        fall     = terminal & oAUD_BCK;
        wrap     = bit_idx == IW'(FW - 1);
        next_idx = wrap ? '0 : bit_idx + IW'(1);
        accept   = iValid & ~hold_full;
    end

    // bit clock divider: toggle BCLK every BCLK_DIV system cycles
    always_ff @(posedge iCLK) begin
        if (reset_h) begin
            div      <= '0;
            oAUD_BCK <= 1'b0;
        end else if (terminal) begin
            div      <= '0;
            oAUD_BCK <= ~oAUD_BCK;
        end else begin
            div <= div + DW'(1);
        end
    end

    // serializer: load the held pair (or silence) at frame start, otherwise shift one bit per falling BCLK
    always_ff @(posedge iCLK) begin
        if (reset_h) begin
            bit_idx   <= IW'(FW - 1);
            shift     <= '0;
            oAUD_DATA <= 1'b0;
            oAUD_LRCK <= 1'b0;
            oFrame    <= 1'b0;
            oUnderrun <= 1'b0;
        end else begin
            oFrame    <= fall & wrap;
            oUnderrun <= fall & wrap & ~hold_full;
            if (fall) begin
                bit_idx <= next_idx;
                if (wrap) begin
                    oAUD_LRCK <= 1'b1;
                    oAUD_DATA <= hold_full & hold_l[DATA_W-1];
                    shift     <= hold_full ? {hold_l, hold_r} << 1 : '0;
                end else begin
                    oAUD_LRCK <= (next_idx == IW'(DATA_W)) ? 1'b0 : oAUD_LRCK;
                    oAUD_DATA <= shift[FW-1];
                    shift     <= shift << 1;
                end
            end
        end
    end

    // one-deep holding register: filled by a handshake, emptied at frame start
    always_ff @(posedge iCLK) begin
        if (reset_h) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= iL;
            hold_r    <= iR;
        end else if (fall & wrap) begin
            hold_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: directed checks of divider timing, framing, handshake and reset for the DAC serializer
module tb_audio_dac_serializer;
    logic        iCLK = 1'b0;
    logic        reset_h = 1'b1;
    logic [15:0] iL = '0;
    logic [15:0] iR = '0;
    logic        iValid = 1'b0;
    logic        oReady, oAUD_BCK, oAUD_LRCK, oAUD_DATA, oFrame, oUnderrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] rx_word[$];
    logic [31:0] rx_lr[$];
    bit          rx_und[$];
    int          rx_cyc[$];
    int          mon_cnt = 32;
    logic [31:0] mon_word, mon_lr;
    bit          mon_und;
    int          mon_cyc;
    logic        prev_bck = 1'b0;

    audio_dac_serializer #(.DATA_W(16), .BCLK_DIV(2)) dut (
        .iCLK(iCLK), .reset_h(reset_h), .iL(iL), .iR(iR), .iValid(iValid),
        .oReady(oReady), .oAUD_BCK(oAUD_BCK), .oAUD_LRCK(oAUD_LRCK),
        .oAUD_DATA(oAUD_DATA), .oFrame(oFrame), .oUnderrun(oUnderrun)
    );

    always #5 iCLK = ~iCLK;

    // capture what the codec would sample on each BCLK rising edge, one record per frame
    always @(negedge iCLK) begin
        if (reset_h) begin
            mon_cnt  = 32;
            prev_bck = 1'b0;
        end else begin
            if (oFrame) begin
                mon_cnt = 0;
                mon_und = oUnderrun;
                mon_cyc = cyc;
            end
            if (oAUD_BCK && !prev_bck && mon_cnt < 32) begin
                mon_word = {mon_word[30:0], oAUD_DATA};
                mon_lr   = {mon_lr[30:0], oAUD_LRCK};
                mon_cnt++;
                if (mon_cnt == 32) begin
                    rx_word.push_back(mon_word);
                    rx_lr.push_back(mon_lr);
                    rx_und.push_back(mon_und);
                    rx_cyc.push_back(mon_cyc);
                end
            end
            prev_bck = oAUD_BCK;
        end
    end

    task automatic tick;
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    task automatic clear_rx;
        rx_word.delete();
        rx_lr.delete();
        rx_und.delete();
        rx_cyc.delete();
    endtask

    task automatic do_reset;
        reset_h = 1'b1;
        iValid  = 1'b0;
        tick();
        tick();
        clear_rx();
        reset_h = 1'b0;
        cyc     = 0;
    endtask

    task automatic wait_rx(input int n, input int lim, output bit ok);
        int k;
        k = 0;
        while (rx_word.size() < n && k < lim) begin
            tick();
            k++;
        end
        ok = rx_word.size() >= n;
    endtask

    task automatic accept_pair(input logic [15:0] l, input logic [15:0] r);
        iL     = l;
        iR     = r;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
    endtask

    task automatic test_reset;
        reset_h = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({oAUD_BCK, oAUD_LRCK, oAUD_DATA, oFrame, oUnderrun, oReady} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=000001", {oAUD_BCK, oAUD_LRCK, oAUD_DATA, oFrame, oUnderrun, oReady});
        end
        clear_rx();
        reset_h = 1'b0;
        cyc = 0;
        tick();
        n_cmp++;
        if (oAUD_BCK !== 1'b0) begin n_err++; $display("FAIL bck_c1 got=%b want=0", oAUD_BCK); end
        tick();
        n_cmp++;
        if (oAUD_BCK !== 1'b1) begin n_err++; $display("FAIL bck_c2 got=%b want=1", oAUD_BCK); end
        tick();
        n_cmp++;
        if ({oAUD_BCK, oFrame} !== 2'b10) begin n_err++; $display("FAIL c3 bck,frame got=%b want=10", {oAUD_BCK, oFrame}); end
        tick();
        n_cmp++;
        if ({oAUD_BCK, oFrame, oUnderrun, oAUD_LRCK, oAUD_DATA} !== 5'b01110) begin
            n_err++;
            $display("FAIL c4 bck,frame,und,lrck,data got=%b want=01110", {oAUD_BCK, oFrame, oUnderrun, oAUD_LRCK, oAUD_DATA});
        end
        repeat (127) tick();
        n_cmp++;
        if (oFrame !== 1'b0) begin n_err++; $display("FAIL frame_c131 got=%b want=0", oFrame); end
        tick();
        n_cmp++;
        if ({oFrame, oUnderrun} !== 2'b11) begin n_err++; $display("FAIL frame_c132 got=%b want=11", {oFrame, oUnderrun}); end
    endtask

    task automatic test_pair;
        bit ok;
        do_reset();
        accept_pair(16'hA5C3, 16'h0F01);
        n_cmp++;
        if (oReady !== 1'b0) begin n_err++; $display("FAIL pair_ready got=%b want=0", oReady); end
        wait_rx(1, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL pair_timeout got=%0d frames want=1", rx_word.size());
        end else begin
            n_cmp++;
            if (rx_word[0] !== 32'hA5C3_0F01) begin n_err++; $display("FAIL pair_word got=%h want=a5c30f01", rx_word[0]); end
            n_cmp++;
            if (rx_lr[0] !== 32'hFFFF_0000) begin n_err++; $display("FAIL pair_lrck got=%h want=ffff0000", rx_lr[0]); end
            n_cmp++;
            if ({rx_und[0], rx_cyc[0]} !== {1'b0, 32'd4}) begin n_err++; $display("FAIL pair_und_cyc got=%0d/%0d want=0/4", rx_und[0], rx_cyc[0]); end
        end
    endtask

    task automatic test_midframe;
        bit ok;
        do_reset();
        while (cyc < 60) tick();
        accept_pair(16'h1234, 16'h5678);
        wait_rx(2, 400, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL mid_timeout got=%0d frames want=2", rx_word.size());
        end else begin
            n_cmp++;
            if ({rx_und[0], rx_word[0]} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL mid_frame1 got=%0d/%h want=1/00000000", rx_und[0], rx_word[0]); end
            n_cmp++;
            if ({rx_und[1], rx_cyc[1]} !== {1'b0, 32'd132}) begin n_err++; $display("FAIL mid_frame2_cyc got=%0d/%0d want=0/132", rx_und[1], rx_cyc[1]); end
            n_cmp++;
            if (rx_word[1] !== 32'h1234_5678) begin n_err++; $display("FAIL mid_word got=%h want=12345678", rx_word[1]); end
        end
    endtask

    task automatic test_extremes;
        bit ok;
        do_reset();
        accept_pair(16'h8000, 16'h7FFF);
        wait_rx(1, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL ext_timeout got=%0d frames want=1", rx_word.size());
        end else begin
            n_cmp++;
            if (rx_word[0] !== 32'h8000_7FFF) begin n_err++; $display("FAIL ext_word got=%h want=80007fff", rx_word[0]); end
            n_cmp++;
            if (rx_lr[0] !== 32'hFFFF_0000) begin n_err++; $display("FAIL ext_lrck got=%h want=ffff0000", rx_lr[0]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [15:0] k;
        int n_acc;
        bit acc, ok;
        do_reset();
        k = 16'd1;
        n_acc = 0;
        iValid = 1'b1;
        iL = k;
        iR = ~k;
        for (int i = 0; i < 300; i++) begin
            acc = iValid && oReady;
            tick();
            if (acc) begin
                exp_q.push_back({iL, iR});
                n_acc++;
                n_cmp++;
                if (oReady !== 1'b0) begin n_err++; $display("FAIL b2b_ready_low cyc=%0d got=%b want=0", cyc, oReady); end
                k = k + 16'd1;
                iL = k;
                iR = ~k;
            end
            if (oFrame) begin
                n_cmp++;
                if (oReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready_high cyc=%0d got=%b want=1", cyc, oReady); end
            end
        end
        iValid = 1'b0;
        n_cmp++;
        if (n_acc !== 4) begin n_err++; $display("FAIL b2b_accepts got=%0d want=4", n_acc); end
        wait_rx(4, 400, ok);
        n_cmp++;
        if (!ok || exp_q.size() < 4) begin
            n_err++;
            $display("FAIL b2b_timeout got=%0d frames want=4", rx_word.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if ({rx_und[i], rx_word[i]} !== {1'b0, exp_q[i]}) begin
                    n_err++;
                    $display("FAIL b2b_frame%0d got=%0d/%h want=0/%h", i, rx_und[i], rx_word[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        accept_pair(16'hCAFE, 16'hBEEF);
        while (cyc < 5) tick();
        accept_pair(16'h1111, 16'h2222);
        while (cyc < 84) tick();
        n_cmp++;
        if (oReady !== 1'b0) begin n_err++; $display("FAIL rmid_held got=%b want=0", oReady); end
        reset_h = 1'b1;
        tick();
        n_cmp++;
        if ({oAUD_BCK, oAUD_LRCK, oAUD_DATA, oFrame, oUnderrun, oReady} !== 6'b000001) begin
            n_err++;
            $display("FAIL rmid_outputs got=%b want=000001", {oAUD_BCK, oAUD_LRCK, oAUD_DATA, oFrame, oUnderrun, oReady});
        end
        clear_rx();
        reset_h = 1'b0;
        cyc = 0;
        wait_rx(1, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rmid_timeout got=%0d frames want=1", rx_word.size());
        end else begin
            n_cmp++;
            if ({rx_und[0], rx_cyc[0], rx_word[0]} !== {1'b1, 32'd4, 32'h0}) begin
                n_err++;
                $display("FAIL rmid_first_frame got=%0d/%0d/%h want=1/4/00000000", rx_und[0], rx_cyc[0], rx_word[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_midframe();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
